// File: rtl/uart_pkg.sv
// Types and constants shared by the UART receive and transmit paths.
package uart_pkg;

  localparam int DATA_BITS = 8;

  // Bit period at 115200 baud from the 50 MHz board clock; the transmit timer uses the same value.
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the serial pin plus a falling-edge detector on the synchronized level.
module rx_sync (
  input  logic clk_50M,
  input  logic reset,
  input  logic rxd,
  output logic level,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // All flops come up high so that reset never looks like a start edge.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= rxd;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign fall  = prev & ~sync;

endmodule

// File: rtl/uart_rxd_ctrl.sv
// 8N1 UART receiver: mid-bit sampling of the synchronized pin, byte delivery with a
// one-cycle complete strobe or a one-cycle framing-error strobe.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a synchronized falling edge
// RX_START | counting to the middle of the start bit to reject glitches
// RX_DATA  | sampling the eight data bits, LSB first, one bit period apart
// RX_STOP  | sampling the stop bit, then delivering the byte or flagging an error
module uart_rxd_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] read_value,
  output logic       read_complete,
  output logic       read_error,
  output logic       rx_busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  logic rxd_level;
  logic rxd_fall;

  rx_sync u_rx_sync (
    .clk_50M (clk_50M),
    .reset   (reset),
    .rxd     (uart_rxd),
    .level   (rxd_level),
    .fall    (rxd_fall)
  );

  rx_state_t              state,    state_nxt;
  logic [CW-1:0]          cnt,      cnt_nxt;
  logic [2:0]             bit_idx,  idx_nxt;
  logic [DATA_BITS-1:0]   shift,    shift_nxt;
  logic [DATA_BITS-1:0]   value_nxt;
  logic                   complete_nxt;
  logic                   error_nxt;
  logic                   busy_nxt;

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state         <= RX_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      read_value    <= '0;
      read_complete <= 1'b0;
      read_error    <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bit_idx       <= idx_nxt;
      shift         <= shift_nxt;
      read_value    <= value_nxt;
      read_complete <= complete_nxt;
      read_error    <= error_nxt;
      rx_busy       <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt + 1'b1;
    idx_nxt      = bit_idx;
    shift_nxt    = shift;
    value_nxt    = read_value;
    complete_nxt = 1'b0;
    error_nxt    = 1'b0;
    busy_nxt     = rx_busy;

    case (state)
      RX_IDLE: begin
        cnt_nxt = '0;
        if (rxd_fall) begin
          state_nxt = RX_START;
          busy_nxt  = 1'b1;
        end
      end

      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          idx_nxt = '0;
          // A line already back high at mid-start was only a glitch.
          if (rxd_level) begin
            state_nxt = RX_IDLE;
            busy_nxt  = 1'b0;
          end else begin
            state_nxt = RX_DATA;
          end
        end
      end

      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          shift_nxt = {rxd_level, shift[DATA_BITS-1:1]};
          if (bit_idx == IDX_LAST) begin
            state_nxt = RX_STOP;
          end else begin
            idx_nxt = bit_idx + 3'd1;
          end
        end
      end

      RX_STOP: begin
        // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = RX_IDLE;
          busy_nxt  = 1'b0;
          if (rxd_level) begin
            value_nxt    = shift;
            complete_nxt = 1'b1;
          end else begin
            error_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = RX_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
